fifo_drive_arbiter: RTL and testbench

- Synchronous scheduler that shares the drive input of one asynchronous click-based FIFO control stage among N_REQ clocked requesters.
- Picks one requester round-robin and launches one 2-phase token into the stage per grant.
- Synchronizes the stage's free and downstream driveNext toggles back into the clock domain.
- Caps tokens in flight with a credit counter; sits at the sync/async boundary in front of the micro-pipeline.

---
 rtl/fifo_drive_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_fifo_drive_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drive_arbiter.sv
// fifo_drive_arbiter: round-robin scheduler that shares the drive input of a
// single asynchronous click-based FIFO control stage among N_REQ clocked
// requesters. It launches one 2-phase token per grant, synchronizes the
// stage's free/driveNext toggles back into clk, and limits tokens in flight
// with a credit counter.
// Optional build macro: FIFO_DRV_WATCHDOG_EN adds a WAIT_FREE watchdog that
// sets the sticky o_err flag. Without the macro, o_err is tied to 0.

module fifo_drive_arbiter #(
  parameter int N_REQ       = 4,
  parameter int IDW         = 2,
  parameter int MAX_OUT     = 2,
  parameter int CW          = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TO_CYC      = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] i_req,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IDW-1:0]   o_gnt_id,
  output logic             o_drive,
  input  logic             i_free,
  input  logic             i_done,
  output logic             o_busy,
  output logic [CW-1:0]    o_credits,
  output logic             o_err
);

  typedef enum logic {
    S_IDLE      = 1'b0,
    S_WAIT_FREE = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Async input synchronizers and toggle-to-pulse conversion
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] free_sync_q;
  logic [SYNC_STAGES-1:0] done_sync_q;
  logic                   free_prev_q;
  logic                   done_prev_q;
  logic                   free_evt;
  logic                   done_evt;

  // Shift the raw toggles through the synchronizer chain and remember the last
  // synchronized phase so that every transition yields one single-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      free_sync_q <= '0;
      done_sync_q <= '0;
      free_prev_q <= 1'b0;
      done_prev_q <= 1'b0;
    end else begin
      free_sync_q <= {free_sync_q[SYNC_STAGES-2:0], i_free};
      done_sync_q <= {done_sync_q[SYNC_STAGES-2:0], i_done};
      free_prev_q <= free_sync_q[SYNC_STAGES-1];
      done_prev_q <= done_sync_q[SYNC_STAGES-1];
    end
  end

  assign free_evt = free_sync_q[SYNC_STAGES-1] ^ free_prev_q;
  assign done_evt = done_sync_q[SYNC_STAGES-1] ^ done_prev_q;

  // ---------------------------------------------------------------------------
  // Round-robin winner selection, searching upward from the pointer
  // ---------------------------------------------------------------------------
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   cand_idx [N_REQ];
  logic [N_REQ-1:0] cand_req;
  logic [IDW-1:0]   win_idx;
  logic [IDW-1:0]   ptr_next;
  logic [N_REQ-1:0] win_onehot;
  logic             req_any;

  // Candidate gi is the requester gi positions after the pointer, modulo N_REQ.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    localparam logic [IDW:0] OFFS   = (IDW+1)'(gi);
    localparam logic [IDW:0] NREQ_W = (IDW+1)'(N_REQ);
    logic [IDW:0] sum;
    assign sum           = {1'b0, ptr_q} + OFFS;
    assign cand_idx[gi]  = (sum >= NREQ_W) ? IDW'(sum - NREQ_W) : sum[IDW-1:0];
    assign cand_req[gi]  = i_req[cand_idx[gi]];
  end

  // The nearest requesting candidate to the pointer wins (lowest offset).
  always_comb begin
    win_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        win_idx = cand_idx[k];
      end
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
    assign win_onehot[gi] = (win_idx == IDW'(gi));
  end

  assign req_any  = |i_req;
  assign ptr_next = (win_idx == IDW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

  // ---------------------------------------------------------------------------
  // Launch decision and credit accounting
  // ---------------------------------------------------------------------------
  state_t        state_q;
  logic [CW-1:0] credits_q;
  logic [CW-1:0] credits_d;
  logic          launch;
  logic          wd_expire;
  logic          wd_err;

  assign launch = (state_q == S_IDLE) && req_any &&
                  (credits_q < CW'(MAX_OUT)) && !wd_err;

  // A completion with nothing in flight is ignored, so it can never cancel a
  // launch or make the counter wrap below zero.
  always_comb begin
    credits_d = credits_q;
    if (launch && !(done_evt && (credits_q != '0))) begin
      credits_d = credits_q + 1'b1;
    end else if (!launch && done_evt && (credits_q != '0)) begin
      credits_d = credits_q - 1'b1;
    end
  end

  // Credit counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits_q <= '0;
    end else begin
      credits_q <= credits_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered grant, index, drive and busy outputs
  // ---------------------------------------------------------------------------
  logic [N_REQ-1:0] gnt_q;
  logic [IDW-1:0]   gnt_id_q;
  logic             drive_q;
  logic             busy_q;

  // IDLE launches one token per grant; WAIT_FREE holds off further grants until
  // the stage reports free (or the watchdog gives up on it).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      drive_q  <= 1'b0;
      busy_q   <= 1'b0;
      ptr_q    <= '0;
    end else begin
      gnt_q <= '0;
      case (state_q)
        S_IDLE: begin
          // A free toggle seen here is spurious and deliberately ignored.
          if (launch) begin
            gnt_q    <= win_onehot;
            gnt_id_q <= win_idx;
            drive_q  <= ~drive_q;
            ptr_q    <= ptr_next;
            busy_q   <= 1'b1;
            state_q  <= S_WAIT_FREE;
          end
        end
        S_WAIT_FREE: begin
          if (free_evt || wd_expire) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Optional WAIT_FREE watchdog
  // ---------------------------------------------------------------------------
`ifdef FIFO_DRV_WATCHDOG_EN
  localparam int WDW = $clog2(TO_CYC + 1);
  logic [WDW-1:0] wd_cnt_q;
  logic           err_q;

  // Fires on the TO_CYC-th WAIT_FREE cycle without a free event.
  assign wd_expire = (state_q == S_WAIT_FREE) && !free_evt &&
                     (wd_cnt_q == WDW'(TO_CYC - 1));

  // Count cycles spent in WAIT_FREE (zero on entry); the error is sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q != S_WAIT_FREE) begin
        wd_cnt_q <= '0;
      end else begin
        wd_cnt_q <= wd_cnt_q + 1'b1;
      end
      if (wd_expire) begin
        err_q <= 1'b1;
      end
    end
  end

  assign wd_err = err_q;
`else
  logic unused_to_cyc;
  assign unused_to_cyc = (TO_CYC == 0);
  assign wd_expire     = 1'b0;
  assign wd_err        = 1'b0;
`endif

  assign o_gnt     = gnt_q;
  assign o_gnt_id  = gnt_id_q;
  assign o_drive   = drive_q;
  assign o_busy    = busy_q;
  assign o_credits = credits_q;
  assign o_err     = wd_err;

endmodule

// File: tb/tb_fifo_drive_arbiter.sv
// Self-checking bench for fifo_drive_arbiter: table of round-robin vectors plus
// hand-written sequences for credits, coincident launch/done, spurious free,
// watchdog (FIFO_DRV_WATCHDOG_EN) and mid-operation reset.

module tb_fifo_drive_arbiter;

  localparam int N_REQ       = 4;
  localparam int IDW         = 2;
  localparam int MAX_OUT     = 2;
  localparam int CW          = 2;
  localparam int SYNC_STAGES = 2;
  localparam int TO_CYC      = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N_REQ-1:0] i_req = '0;
  logic             i_free = 1'b0;
  logic             i_done = 1'b0;
  logic [N_REQ-1:0] o_gnt;
  logic [IDW-1:0]   o_gnt_id;
  logic             o_drive;
  logic             o_busy;
  logic [CW-1:0]    o_credits;
  logic             o_err;

  always #5 clk = ~clk;

  fifo_drive_arbiter #(
    .N_REQ(N_REQ), .IDW(IDW), .MAX_OUT(MAX_OUT), .CW(CW),
    .SYNC_STAGES(SYNC_STAGES), .TO_CYC(TO_CYC)
  ) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .o_gnt(o_gnt), .o_gnt_id(o_gnt_id),
    .o_drive(o_drive), .i_free(i_free), .i_done(i_done), .o_busy(o_busy),
    .o_credits(o_credits), .o_err(o_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a grant pulse; an expired bound counts as a failure.
  task automatic wait_grant(input string name, input int budget, output logic [N_REQ-1:0] g);
    bit seen;
    seen = 1'b0;
    g    = '0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (o_gnt != '0) begin
        g    = o_gnt;
        seen = 1'b1;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no grant within %0d cycles", name, budget);
    end
  endtask

  // Stage model: free toggles 3 cycles after each drive edge, done 5 later.
  bit   model_free_en = 1'b1;
  bit   model_done_en = 1'b1;
  int   cyc = 0;
  int   drv_toggles = 0;
  int   free_at[$];
  int   done_at[$];
  logic last_drive = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        free_at.delete();
        done_at.delete();
        last_drive = o_drive;
      end else begin
        if (o_drive !== last_drive) begin
          last_drive = o_drive;
          drv_toggles++;
          if (model_free_en) free_at.push_back(cyc + 3);
          if (model_done_en) done_at.push_back(cyc + 8);
        end
        if (free_at.size() > 0 && free_at[0] == cyc) begin
          void'(free_at.pop_front());
          i_free = ~i_free;
        end
        if (done_at.size() > 0 && done_at[0] == cyc) begin
          void'(done_at.pop_front());
          i_done = ~i_done;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [IDW-1:0]   id;
  } vec_t;

  initial begin
    vec_t             vecs [10];
    logic [N_REQ-1:0] g;
    int               cnt;

    // Pointer starts at 1 after the first post-reset grant to req0.
    vecs[0] = '{4'b1111, 4'b0010, 2'd1};
    vecs[1] = '{4'b1111, 4'b0100, 2'd2};
    vecs[2] = '{4'b1111, 4'b1000, 2'd3};
    vecs[3] = '{4'b1111, 4'b0001, 2'd0};
    vecs[4] = '{4'b1001, 4'b1000, 2'd3};
    vecs[5] = '{4'b0110, 4'b0010, 2'd1};
    vecs[6] = '{4'b0011, 4'b0001, 2'd0};
    vecs[7] = '{4'b0100, 4'b0100, 2'd2};
    vecs[8] = '{4'b1010, 4'b1000, 2'd3};
    vecs[9] = '{4'b1110, 4'b0010, 2'd1};

    // ---- Reset with all requests pending ----
    rst   = 1'b1;
    i_req = 4'b1111;
    repeat (3) tick();
    chk("rst_gnt", 32'(o_gnt), 32'(0));
    chk("rst_drive", 32'(o_drive), 32'(0));
    chk("rst_credits", 32'(o_credits), 32'(0));
    chk("rst_busy", 32'(o_busy), 32'(0));
    chk("rst_gnt_id", 32'(o_gnt_id), 32'(0));
    chk("rst_err", 32'(o_err), 32'(0));
    rst = 1'b0;
    tick();
    chk("first_gnt", 32'(o_gnt), 32'(4'b0001));
    chk("first_gnt_id", 32'(o_gnt_id), 32'(0));
    chk("first_drive", 32'(o_drive), 32'(1));
    chk("first_credits", 32'(o_credits), 32'(1));
    chk("first_busy", 32'(o_busy), 32'(1));
    tick();
    chk("first_gnt_pulse", 32'(o_gnt), 32'(0));

    // ---- Round-robin table ----
    for (int v = 0; v < 10; v++) begin
      i_req = vecs[v].req;
      wait_grant($sformatf("rr_wait[%0d]", v), 40, g);
      chk($sformatf("rr_gnt[%0d]", v), 32'(g), 32'(vecs[v].gnt));
      chk($sformatf("rr_id[%0d]", v), 32'(o_gnt_id), 32'(vecs[v].id));
      tick();
      chk($sformatf("rr_pulse[%0d]", v), 32'(o_gnt), 32'(0));
    end
    i_req = '0;
    repeat (30) tick();
    chk("rr_drive_toggles", 32'(drv_toggles), 32'(11));
    chk("rr_credits_drained", 32'(o_credits), 32'(0));
    chk("rr_idle", 32'(o_busy), 32'(0));

    // ---- Credit limit: done withheld ----
    model_done_en = 1'b0;
    i_req = 4'b0001;
    wait_grant("cred_wait1", 40, g);
    chk("cred_gnt1", 32'(g), 32'(4'b0001));
    wait_grant("cred_wait2", 40, g);
    chk("cred_gnt2", 32'(g), 32'(4'b0001));
    cnt = 0;
    repeat (30) begin
      tick();
      if (o_gnt != '0) cnt++;
    end
    chk("cred_blocked_grants", 32'(cnt), 32'(0));
    chk("cred_full", 32'(o_credits), 32'(2));
    chk("cred_full_busy", 32'(o_busy), 32'(0));
    i_done = ~i_done;
    repeat (3) tick();
    chk("cred_after_done", 32'(o_credits), 32'(1));
    chk("cred_no_gnt_yet", 32'(o_gnt), 32'(0));
    tick();
    chk("cred_regrant", 32'(o_gnt), 32'(4'b0001));
    chk("cred_regrant_credits", 32'(o_credits), 32'(2));
    i_req = '0;
    repeat (12) tick();
    i_done = ~i_done;
    repeat (5) tick();
    i_done = ~i_done;
    repeat (5) tick();
    chk("cred_drained", 32'(o_credits), 32'(0));

    // ---- Launch and done in the same cycle ----
    i_req = 4'b0001;
    wait_grant("sim_wait", 40, g);
    chk("sim_gnt", 32'(g), 32'(4'b0001));
    i_req = '0;
    repeat (12) tick();
    chk("sim_credits_pre", 32'(o_credits), 32'(1));
    chk("sim_idle_pre", 32'(o_busy), 32'(0));
    i_done = ~i_done;
    tick();
    tick();
    chk("sim_credits_e2", 32'(o_credits), 32'(1));
    i_req = 4'b0001;
    tick();
    chk("sim_launch_gnt", 32'(o_gnt), 32'(4'b0001));
    chk("sim_credits_same", 32'(o_credits), 32'(1));
    i_req = '0;
    repeat (12) tick();
    i_done = ~i_done;
    repeat (5) tick();
    chk("sim_credits_zero", 32'(o_credits), 32'(0));
    i_done = ~i_done;
    repeat (5) tick();
    chk("underflow_guard", 32'(o_credits), 32'(0));

    // ---- Spurious free while idle ----
    i_free = ~i_free;
    cnt = 0;
    repeat (6) begin
      tick();
      if (o_busy || (o_gnt != '0)) cnt++;
    end
    chk("spur_no_activity", 32'(cnt), 32'(0));
    i_req = 4'b0100;
    tick();
    chk("spur_then_gnt", 32'(o_gnt), 32'(4'b0100));
    chk("spur_then_id", 32'(o_gnt_id), 32'(2));
    i_req = '0;
    repeat (12) tick();
    i_done = ~i_done;
    repeat (5) tick();
    chk("spur_credits_zero", 32'(o_credits), 32'(0));

    // ---- Watchdog: free never returns ----
    model_free_en = 1'b0;
    i_req = 4'b0001;
    tick();
    chk("wd_gnt", 32'(o_gnt), 32'(4'b0001));
    repeat (19) tick();
    chk("wd_busy_c19", 32'(o_busy), 32'(1));
    chk("wd_err_c19", 32'(o_err), 32'(0));
    tick();
`ifdef FIFO_DRV_WATCHDOG_EN
    chk("wd_err_c20", 32'(o_err), 32'(1));
    chk("wd_busy_c20", 32'(o_busy), 32'(0));
`else
    chk("wd_err_c20", 32'(o_err), 32'(0));
    chk("wd_busy_c20", 32'(o_busy), 32'(1));
`endif
    cnt = 0;
    repeat (10) begin
      tick();
      if (o_gnt != '0) cnt++;
    end
    chk("wd_no_grants", 32'(cnt), 32'(0));
    chk("wd_credits", 32'(o_credits), 32'(1));
`ifdef FIFO_DRV_WATCHDOG_EN
    chk("wd_err_sticky", 32'(o_err), 32'(1));
`else
    chk("wd_still_busy", 32'(o_busy), 32'(1));
`endif

    // ---- Reset in the middle of operation ----
    rst    = 1'b1;
    i_free = 1'b0;
    i_done = 1'b0;
    tick();
    chk("mid_rst_busy", 32'(o_busy), 32'(0));
    chk("mid_rst_credits", 32'(o_credits), 32'(0));
    chk("mid_rst_drive", 32'(o_drive), 32'(0));
    chk("mid_rst_gnt_id", 32'(o_gnt_id), 32'(0));
    chk("mid_rst_err", 32'(o_err), 32'(0));
    chk("mid_rst_gnt", 32'(o_gnt), 32'(0));
    i_req = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
